sevenseg_scan: RTL and testbench

//  Time-multiplexed seven-segment display driver, directly downstream of clk_div.

---
 rtl/sevenseg_scan_pkg.sv | 23 ++
 rtl/sevenseg_scan_hex_to_7seg.sv | 14 +
 rtl/sevenseg_scan.sv | 167 ++++++++++++++++
 tb/tb_sevenseg_scan.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_scan_pkg.sv
// Shared definitions for the seven-segment scan driver and its decoder.
// Contents:
//   scan_state_e  : scan FSM states (ST_DRIVE, ST_BLANK)
//   SEG_OFF       : active-low segment pattern with every segment dark
//   HEX_SEG_TABLE : 16-entry hex-to-segment table, {g,f,e,d,c,b,a}, active-low
package sevenseg_scan_pkg;

  typedef enum logic {
    ST_DRIVE = 1'b0,
    ST_BLANK = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry 0 is the rightmost element of the concatenation.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/sevenseg_scan_hex_to_7seg.sv
// Combinational hex nibble to seven-segment decoder, active-low outputs.
// Ports:
//   hex : 4-bit value to display
//   seg : {g,f,e,d,c,b,a}, 0 = segment lit
module hex_to_7seg
  import sevenseg_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[hex];

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed seven-segment display driver. Steps only on clk_en ticks,
// drives one digit at a time with an optional all-dark gap between digits,
// and latches the digit data once per frame so a frame is never mixed.
// Ports:
//   clk        : system clock
//   rst        : synchronous reset, active-low
//   clk_en     : scan tick (single-cycle pulse or held high)
//   digits     : one hex nibble per digit, digit i = digits[4i+3:4i]
//   dp_in      : decimal point request per digit (1 = lit)
//   digit_en   : 1 = digit shown, 0 = digit kept dark in its slot
//   an         : anode selects, active-low
//   seg        : {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low
//   frame_done : one-cycle pulse when the last digit's dwell ends
module sevenseg_scan
  import sevenseg_scan_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int DWELL_TICKS = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int IDX_W   = $clog2(N_DIGITS);
  localparam int CNT_MAX = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

  scan_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  first_q, first_d;
  logic [4*N_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [N_DIGITS-1:0]   snap_en_q, snap_en_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;

  logic                  advance;
  logic [3:0]            cur_nibble;
  logic [6:0]            cur_seg;

  // Scan sequencing. first_q marks the BLANK entered from reset, which leaves
  // on the very first tick regardless of BLANK_TICKS so the scan starts promptly.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    first_d       = first_q;
    snap_digits_d = snap_digits_q;
    snap_dp_d     = snap_dp_q;
    snap_en_d     = snap_en_q;
    frame_done_d  = 1'b0;
    advance       = 1'b0;

    if (clk_en) begin
      case (state_q)
        ST_DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d        = '0;
            frame_done_d = (idx_q == LAST_IDX);
            if (BLANK_TICKS > 0) begin
              state_d = ST_BLANK;
            end else begin
              advance = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_BLANK: begin
          if (first_q || (cnt_q == BLANK_LAST)) begin
            cnt_d   = '0;
            first_d = 1'b0;
            advance = 1'b1;
            state_d = ST_DRIVE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_BLANK;
      endcase
    end

    // Wrapping back to digit 0 is the frame boundary, so that is where the
    // inputs are captured; the new frame's first digit already uses them.
    if (advance) begin
      if (idx_q == LAST_IDX) begin
        idx_d         = '0;
        snap_digits_d = digits;
        snap_dp_d     = dp_in;
        snap_en_d     = digit_en;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  assign cur_nibble = snap_digits_d[{idx_d, 2'b00} +: 4];

  hex_to_7seg u_hex_to_7seg (
    .hex (cur_nibble),
    .seg (cur_seg)
  );

  // Outputs are decoded from the next state so the pins move on the same edge
  // that accepts the tick.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if ((state_d == ST_DRIVE) && snap_en_d[idx_d]) begin
      an_d  = ~(N_DIGITS'(1) << idx_d);
      seg_d = cur_seg;
      dp_d  = ~snap_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_BLANK;
      idx_q         <= LAST_IDX;
      cnt_q         <= '0;
      first_q       <= 1'b1;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      snap_en_q     <= '0;
      an_q          <= '1;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      first_q       <= first_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      snap_en_q     <= snap_en_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Testbench for sevenseg_scan with default parameters (4 digits, dwell 4,
// blank 1). Stimulus pushes the expected pin state for every accepted tick or
// reset cycle; an independent monitor pops and compares one step after the edge.
module tb_sevenseg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   vectors_applied = 0;
  int   miscompares     = 0;
  int   gap             = 4;
  logic fire;

  sevenseg_scan dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .digits     (digits),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Queue the pin state required after the next accepted edge.
  task automatic pushExp(input logic [3:0] e_an, input logic [6:0] e_seg,
                         input logic e_dp, input logic e_fd, input string name);
    exp_t e;
    e.an   = e_an;
    e.seg  = e_seg;
    e.dp   = e_dp;
    e.fd   = e_fd;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // One scan tick, followed by `gap` idle cycles.
  task automatic applyStimulus(input logic [3:0] e_an, input logic [6:0] e_seg,
                               input logic e_dp, input logic e_fd, input string name);
    pushExp(e_an, e_seg, e_dp, e_fd, name);
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // A full digit slot: four dwell ticks then one blank tick.
  task automatic showDigit(input logic [3:0] e_an, input logic [6:0] e_seg,
                           input logic e_dp, input logic last, input string name);
    repeat (4) applyStimulus(e_an, e_seg, e_dp, 1'b0, name);
    applyStimulus(4'hF, 7'h7F, 1'b1, last, {name, "_blank"});
  endtask

  // Reset with clk_en high, which must not win over reset.
  task automatic resetPulse(input int n, input string name);
    for (int i = 0; i < n; i++) pushExp(4'hF, 7'h7F, 1'b1, 1'b0, name);
    rst    = 1'b0;
    clk_en = 1'b1;
    repeat (n) @(negedge clk);
    rst    = 1'b1;
    clk_en = 1'b0;
  endtask

  task automatic checkOutput();
    exp_t e;
    vectors_applied++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL unexpected_update: got an=%h seg=%h dp=%b fd=%b, nothing expected",
               an, seg, dp, frame_done);
    end else begin
      e = exp_q.pop_front();
      if ({an, seg, dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
        miscompares++;
        $display("[TB] FAIL %s: got an=%h seg=%h dp=%b fd=%b, want an=%h seg=%h dp=%b fd=%b",
                 e.name, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
      end
    end
  endtask

  // Monitor: an accepted tick or a reset cycle updates the pins; any other
  // cycle must leave frame_done low so the pulse is exactly one clock wide.
  always @(posedge clk) begin
    fire = (rst === 1'b0) || (clk_en === 1'b1);
    #1;
    if (fire) begin
      checkOutput();
    end else if (frame_done !== 1'b0) begin
      vectors_applied++;
      miscompares++;
      $display("[TB] FAIL fd_pulse_width: got frame_done=%b, want 0", frame_done);
    end
  end

  initial begin
    #200000;
    miscompares++;
    $display("[TB] FAIL watchdog: stimulus did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    digits   = 16'h0000;
    dp_in    = 4'b0000;
    digit_en = 4'b1111;
    rst      = 1'b0;
    clk_en   = 1'b0;
    $display("[TB] reset held with clk_en high");
    resetPulse(3, "reset_hold");
    repeat (2) @(negedge clk);

    $display("[TB] frame 1: 8F10");
    digits = 16'h8F10;
    showDigit(4'hE, 7'h40, 1'b1, 1'b0, "f1_d0");
    showDigit(4'hD, 7'h79, 1'b1, 1'b0, "f1_d1");
    showDigit(4'hB, 7'h0E, 1'b1, 1'b0, "f1_d2");
    showDigit(4'h7, 7'h00, 1'b1, 1'b1, "f1_d3");

    $display("[TB] frame 2: inputs change mid-frame");
    showDigit(4'hE, 7'h40, 1'b1, 1'b0, "f2_d0");
    showDigit(4'hD, 7'h79, 1'b1, 1'b0, "f2_d1");
    applyStimulus(4'hB, 7'h0E, 1'b1, 1'b0, "f2_d2");
    digits = 16'h1234;
    repeat (3) applyStimulus(4'hB, 7'h0E, 1'b1, 1'b0, "f2_d2_held");
    applyStimulus(4'hF, 7'h7F, 1'b1, 1'b0, "f2_d2_blank");
    showDigit(4'h7, 7'h00, 1'b1, 1'b1, "f2_d3_held");

    $display("[TB] frame 3: 1234");
    showDigit(4'hE, 7'h19, 1'b1, 1'b0, "f3_d0");
    showDigit(4'hD, 7'h30, 1'b1, 1'b0, "f3_d1");
    digit_en = 4'b1010;
    dp_in    = 4'b0010;
    showDigit(4'hB, 7'h24, 1'b1, 1'b0, "f3_d2");
    showDigit(4'h7, 7'h79, 1'b1, 1'b1, "f3_d3");

    $display("[TB] frame 4: mask 1010, dp 0010");
    showDigit(4'hF, 7'h7F, 1'b1, 1'b0, "f4_d0_masked");
    showDigit(4'hD, 7'h30, 1'b0, 1'b0, "f4_d1_dp");
    digits   = 16'h8F10;
    digit_en = 4'b1111;
    dp_in    = 4'b0001;
    showDigit(4'hF, 7'h7F, 1'b1, 1'b0, "f4_d2_masked");
    showDigit(4'h7, 7'h79, 1'b1, 1'b1, "f4_d3");

    $display("[TB] frame 5: clk_en held high, reset mid-frame");
    gap = 0;
    showDigit(4'hE, 7'h40, 1'b0, 1'b0, "f5_d0_dp");
    showDigit(4'hD, 7'h79, 1'b1, 1'b0, "f5_d1");
    repeat (2) applyStimulus(4'hB, 7'h0E, 1'b1, 1'b0, "f5_d2");
    digits   = 16'hA5C3;
    dp_in    = 4'b0000;
    resetPulse(1, "reset_mid");

    $display("[TB] frame 6: restart at digit 0 with A5C3");
    showDigit(4'hE, 7'h30, 1'b1, 1'b0, "f6_d0");
    showDigit(4'hD, 7'h46, 1'b1, 1'b0, "f6_d1");
    showDigit(4'hB, 7'h12, 1'b1, 1'b0, "f6_d2");
    showDigit(4'h7, 7'h08, 1'b1, 1'b1, "f6_d3");

    repeat (3) @(negedge clk);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors_applied++;
      miscompares++;
      $display("[TB] FAIL %s: got no update, want an=%h seg=%h dp=%b fd=%b",
               e.name, e.an, e.seg, e.dp, e.fd);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
